// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel button-controlled PWM with a shared period counter
// Define PWM_DEBOUNCE_EN to add a DB_CYCLES stability filter on every button.

module pwm_multi #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8,
   parameter int STEP      = 16,
   parameter int DB_CYCLES = 4,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_sel,
   output logic [CHANNELS-1:0]  pwm_out,
   output logic [SEL_W-1:0]     sel_ch,
   output logic [CNT_WIDTH-1:0] duty_sel
);

   localparam logic [CNT_WIDTH-1:0] MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] MAX_M1 = MAX - CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   MAX_W  = {1'b0, MAX};
   localparam logic [CNT_WIDTH:0]   STEP_W = (CNT_WIDTH + 1)'(STEP);
   localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(CHANNELS - 1);

   if (CHANNELS < 1 || CHANNELS > 16 || STEP < 1 || STEP > (2 ** CNT_WIDTH) - 1 || DB_CYCLES < 1)
   begin : g_bad_param
      $error("pwm_multi: parameter out of range");
   end

   // Button bit order everywhere: 0 = left, 1 = right, 2 = sel.
   logic [2:0] sync1_q, sync2_q, prev_q, ev_q, btn_lvl;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         ev_q    <= '0;
      end else begin
         sync1_q <= {btn_sel, btn_right, btn_left};
         sync2_q <= sync1_q;
         prev_q  <= btn_lvl;
         ev_q    <= btn_lvl & ~prev_q;
      end
   end

`ifdef PWM_DEBOUNCE_EN
   localparam int DB_W = $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [2:0][DB_W-1:0] db_cnt_q;
   logic [2:0]           filt_q;

   // Filtered level follows the synchronised level only after DB_CYCLES disagreeing samples in a row.
   always_ff @(posedge clk) begin
      if (!rst) begin
         db_cnt_q <= '0;
         filt_q   <= '0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] == filt_q[b]) begin
               db_cnt_q[b] <= '0;
            end else if (db_cnt_q[b] == DB_LAST) begin
               filt_q[b]   <= sync2_q[b];
               db_cnt_q[b] <= '0;
            end else begin
               db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
            end
         end
      end
   end

   assign btn_lvl = filt_q;
`else
   assign btn_lvl = sync2_q;
`endif

   logic [CNT_WIDTH-1:0]                cnt_q;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0]  shadow_q, shadow_d, active_q;
   logic [SEL_W-1:0]                    sel_q, sel_d;
   logic [CHANNELS-1:0]                 pwm_q;
   logic [CNT_WIDTH:0]                  cur_w, sum_w, diff_w;
   logic                                boundary;

   assign boundary = (cnt_q == MAX_M1);

   // Saturating adjust computed one bit wider so neither direction can wrap.
   always_comb begin
      shadow_d = shadow_q;
      cur_w    = {1'b0, shadow_q[sel_q]};
      sum_w    = cur_w + STEP_W;
      diff_w   = cur_w - STEP_W;
      if (ev_q[1] && !ev_q[0]) begin
         shadow_d[sel_q] = (sum_w > MAX_W) ? MAX : sum_w[CNT_WIDTH-1:0];
      end else if (ev_q[0] && !ev_q[1]) begin
         shadow_d[sel_q] = (cur_w < STEP_W) ? '0 : diff_w[CNT_WIDTH-1:0];
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (ev_q[2]) begin
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= '0;
         sel_q    <= '0;
         pwm_q    <= '0;
      end else begin
         cnt_q    <= boundary ? '0 : cnt_q + CNT_WIDTH'(1);
         shadow_q <= shadow_d;
         sel_q    <= sel_d;
         // Active duties pick up the pre-edge shadows, so a write on this edge waits a full period.
         if (boundary) begin
            active_q <= shadow_q;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_q[i] <= (cnt_q < active_q[i]);
         end
      end
   end

   assign pwm_out  = pwm_q;
   assign sel_ch   = sel_q;
   assign duty_sel = shadow_q[sel_q];

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - randomized self-checking bench for pwm_multi against a duty/selection model
// Build with PWM_DEBOUNCE_EN defined to exercise the debounce configuration.

module tb_pwm_multi;

   localparam int CH   = 2;
   localparam int W    = 4;
   localparam int MAXV = 15;
   localparam int STEP = 4;
   localparam int DB   = 3;
`ifdef PWM_DEBOUNCE_EN
   localparam int LAT = 3 + DB;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
   logic [CH-1:0] pwm_out;
   logic [0:0]    sel_ch;
   logic [W-1:0]  duty_sel;

   int n_tests = 0;
   int n_fail  = 0;
   int sh[CH];
   int sel_m;

   pwm_multi #(.CHANNELS(CH), .CNT_WIDTH(W), .STEP(STEP), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst),
      .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel),
      .pwm_out(pwm_out), .sel_ch(sel_ch), .duty_sel(duty_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_apply(input bit l, input bit r, input bit s);
      if (r && !l) sh[sel_m] = (sh[sel_m] + STEP > MAXV) ? MAXV : sh[sel_m] + STEP;
      else if (l && !r) sh[sel_m] = (sh[sel_m] - STEP < 0) ? 0 : sh[sel_m] - STEP;
      if (s) sel_m = (sel_m == CH - 1) ? 0 : sel_m + 1;
   endfunction

   task automatic press(input bit l, input bit r, input bit s, input int hold, input string tag);
      @(negedge clk);
      btn_left = l; btn_right = r; btn_sel = s;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
      repeat (LAT + 6) @(posedge clk);
      #1;
      model_apply(l, r, s);
      check({tag, "_duty"}, duty_sel, sh[sel_m]);
      check({tag, "_sel"}, sel_ch, sel_m);
   endtask

   // Any 15-cycle window of a settled output holds exactly its duty in high cycles.
   task automatic check_pwm(input string tag);
      int hi[CH];
      int runs[CH];
      logic [CH-1:0] prev;
      repeat (2 * MAXV + 1) @(posedge clk);
      #1;
      prev = pwm_out;
      for (int i = 0; i < CH; i++) begin hi[i] = 0; runs[i] = 0; end
      for (int c = 0; c < MAXV; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < CH; i++) begin
            hi[i] += int'(pwm_out[i]);
            if (pwm_out[i] && !prev[i]) runs[i]++;
         end
         prev = pwm_out;
      end
      for (int i = 0; i < CH; i++) begin
         check($sformatf("%s_hi%0d", tag, i), hi[i], sh[i]);
         check($sformatf("%s_runs%0d", tag, i), runs[i], (sh[i] > 0 && sh[i] < MAXV) ? 1 : 0);
      end
   endtask

   initial begin
      int a, b, k, hold;
      bit found;
      logic p0;

      for (int i = 0; i < CH; i++) sh[i] = 0;
      sel_m = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_pwm", pwm_out, 0);
      check("rst_sel", sel_ch, 0);
      check("rst_duty", duty_sel, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         check("idle_pwm", pwm_out, 0);
      end
      check("idle_sel", sel_ch, 0);
      check("idle_duty", duty_sel, 0);

      // First press with exact latency check.
      @(negedge clk);
      btn_right = 1'b1;
      @(posedge clk);
      repeat (LAT - 1) @(posedge clk);
      #1;
      check("lat_before", duty_sel, 0);
      @(posedge clk);
      #1;
      check("lat_after", duty_sel, STEP);
      repeat (6) @(posedge clk);
      @(negedge clk);
      btn_right = 1'b0;
      repeat (LAT + 6) @(posedge clk);
      model_apply(0, 1, 0);

      press(0, 1, 0, 10, "r2");
      press(0, 1, 0, 10, "r3");
      press(0, 1, 0, 10, "r4_sat");
      check("sat_val", duty_sel, MAXV);
      check_pwm("pwm_full");
      press(1, 0, 0, 10, "l1");
      press(1, 0, 0, 10, "l2");
      check("l2_val", duty_sel, 7);
      check_pwm("pwm_seven");
      press(0, 0, 1, 10, "sel1");
      press(0, 1, 0, 10, "ch1_r");
      check("ch1_val", duty_sel, STEP);
      check_pwm("pwm_ch1");
      press(0, 0, 1, 10, "sel_wrap");
      check("wrap_sel", sel_ch, 0);
      press(1, 1, 0, 10, "both");
      check("both_val", duty_sel, 7);

`ifdef PWM_DEBOUNCE_EN
      @(negedge clk);
      btn_right = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      btn_right = 1'b0;
      repeat (LAT + 10) @(posedge clk);
      #1;
      check("glitch", duty_sel, sh[sel_m]);
`endif

      // Shadow write on the edge that leaves cnt==14: old duty runs one more period.
      found = 1'b0;
      p0 = pwm_out[0];
      for (int c = 0; c < 40 && !found; c++) begin
         @(posedge clk);
         #1;
         if (!p0 && pwm_out[0]) found = 1'b1;
         p0 = pwm_out[0];
      end
      check("rise_found", found, 1);
      a = 0; b = 0;
      repeat (14 - LAT - 1) @(posedge clk);
      @(negedge clk);
      btn_right = 1'b1;
      for (int j = 0; j < LAT + 31; j++) begin
         @(posedge clk);
         #1;
         if (j == 10) btn_right = 1'b0;
         if (j >= LAT + 1 && j <= LAT + 15) a += int'(pwm_out[0]);
         if (j >= LAT + 16 && j <= LAT + 30) b += int'(pwm_out[0]);
      end
      check("bnd_old_period", a, sh[0]);
      model_apply(0, 1, 0);
      check("bnd_new_period", b, sh[0]);
      check("bnd_duty", duty_sel, sh[0]);
      repeat (LAT + 6) @(posedge clk);

      for (int it = 0; it < 14; it++) begin
         k = $urandom_range(0, 5);
         hold = $urandom_range(DB + 2, 9);
         case (k)
            0: press(1, 0, 0, hold, "rnd_l");
            1: press(0, 1, 0, hold, "rnd_r");
            2: press(0, 0, 1, hold, "rnd_s");
            3: press(1, 1, 0, hold, "rnd_lr");
            4: press(0, 1, 1, hold, "rnd_rs");
            default: press(1, 0, 1, hold, "rnd_ls");
         endcase
      end
      check_pwm("pwm_rnd");

      repeat ($urandom_range(1, 14)) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_pwm", pwm_out, 0);
      check("mid_rst_sel", sel_ch, 0);
      check("mid_rst_duty", duty_sel, 0);
      for (int i = 0; i < CH; i++) sh[i] = 0;
      sel_m = 0;
      @(negedge clk);
      rst = 1'b1;
      a = 0;
      for (int c = 0; c < 2 * MAXV; c++) begin
         @(posedge clk);
         #1;
         a += int'(pwm_out != 0);
      end
      check("post_rst_idle", a, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
